// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle for the shared narrow multiplier.
// The master side belongs to the requesters and the consumer; the slave side belongs to the arbiter.
interface mul_share_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 3,
  parameter int B_WIDTH  = 5,
  parameter int P_WIDTH  = 7,
  parameter int ID_WIDTH = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [P_WIDTH-1:0]         rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that shares one truncating unsigned multiplier among NUM_REQ requesters.
// Each product is returned through a single registered response slot tagged with the requester index.
module mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int A_WIDTH     = 3,
  parameter int B_WIDTH     = 5,
  parameter int P_WIDTH     = 7,
  parameter int ID_WIDTH    = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  mul_share_arbiter_if.slave     bus,
  output logic [COUNT_WIDTH-1:0] op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rsp_state_t;

  rsp_state_t          state;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] resp_id;
  logic [P_WIDTH-1:0]  resp_product;

  logic [NUM_REQ-1:0]  hit_hi;
  logic [NUM_REQ-1:0]  hit_lo;
  logic                found;
  logic [ID_WIDTH-1:0] grant;
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;
  logic                can_load;
  logic                accept;
  logic [NUM_REQ-1:0]  ready_vec;

  function automatic logic [P_WIDTH-1:0] mul_trunc(
    input logic [A_WIDTH-1:0] a,
    input logic [B_WIDTH-1:0] b
  );
    logic [A_WIDTH+B_WIDTH-1:0] full;
    full = {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};
    return full[P_WIDTH-1:0];
  endfunction

  // Rotating priority: indices above last_grant win first, then the scan wraps to the low indices.
  always_comb begin
    found  = 1'b0;
    grant  = '0;
    sel_a  = '0;
    sel_b  = '0;
    hit_hi = '0;
    hit_lo = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_hi[i] = !found && bus.req_valid[i] && (ID_WIDTH'(i) > last_grant);
      found     = found | hit_hi[i];
      grant     = hit_hi[i] ? ID_WIDTH'(i) : grant;
      sel_a     = hit_hi[i] ? bus.req_a[i*A_WIDTH +: A_WIDTH] : sel_a;
      sel_b     = hit_hi[i] ? bus.req_b[i*B_WIDTH +: B_WIDTH] : sel_b;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_lo[i] = !found && bus.req_valid[i] && (ID_WIDTH'(i) <= last_grant);
      found     = found | hit_lo[i];
      grant     = hit_lo[i] ? ID_WIDTH'(i) : grant;
      sel_a     = hit_lo[i] ? bus.req_a[i*A_WIDTH +: A_WIDTH] : sel_a;
      sel_b     = hit_lo[i] ? bus.req_b[i*B_WIDTH +: B_WIDTH] : sel_b;
    end
  end

  // Load is allowed when the slot is empty or drains this cycle; ready is held low during reset.
  always_comb begin
    can_load  = (state == EMPTY) || bus.rsp_ready;
    accept    = found && can_load && !ap_rst;
    ready_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_vec[i] = accept && (grant == ID_WIDTH'(i));
    end
  end

  assign bus.req_ready   = ready_vec;
  assign bus.rsp_valid   = (state == FULL);
  assign bus.rsp_id      = resp_id;
  assign bus.rsp_product = resp_product;

  // Response slot FSM with pointer and counter; an accept overrides a simultaneous drain.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state        <= EMPTY;
      last_grant   <= ID_WIDTH'(NUM_REQ - 1);
      resp_id      <= '0;
      resp_product <= '0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        resp_id      <= grant;
        resp_product <= mul_trunc(sel_a, sel_b);
        last_grant   <= grant;
        op_count     <= op_count + COUNT_WIDTH'(1);
      end else begin
        op_count     <= op_count;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
          end else begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (accept) begin
            state <= FULL;
          end else if (bus.rsp_ready) begin
            state <= EMPTY;
          end else begin
            state <= FULL;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a queue-free arithmetic reference of the arbiter.
module tb_mul_share_arbiter;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int BW = 5;
  localparam int PW = 7;
  localparam int IW = 2;
  localparam int CW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [CW-1:0] op_count;

  mul_share_arbiter_if #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)) bus ();

  mul_share_arbiter #(
    .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW), .COUNT_WIDTH(CW)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] a_op [N];
  logic [BW-1:0] b_op [N];
  logic [N-1:0]  vld;
  logic          rdy;
  logic [N-1:0]  last_ready;
  logic [N-1:0]  obs_ready;

  // reference model state
  int m_lg;
  int m_id;
  int m_prod;
  int m_cnt;
  bit m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive();
    bus.req_valid = vld;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*AW +: AW] = a_op[i];
      bus.req_b[i*BW +: BW] = b_op[i];
    end
    bus.rsp_ready = rdy;
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_lg + k) % N;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check DUT against the model mid-cycle, then advance the model over the edge.
  task automatic cycle();
    int g;
    bit can, acc;
    logic [N-1:0] exp_ready;
    drive();
    @(negedge ap_clk);
    g = model_grant();
    can = !m_valid || rdy;
    acc = (g >= 0) && can;
    exp_ready = acc ? (N'(1) << g) : '0;
    obs_ready = bus.req_ready;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    check("rsp_id", 32'(bus.rsp_id), m_id);
    check("rsp_product", 32'(bus.rsp_product), m_prod);
    check("op_count", 32'(op_count), m_cnt);
    if (acc) begin
      m_prod  = (int'(a_op[g]) * int'(b_op[g])) % (1 << PW);
      m_id    = g;
      m_valid = 1'b1;
      m_lg    = g;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    last_ready = exp_ready;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    m_lg = N - 1; m_id = 0; m_prod = 0; m_cnt = 0; m_valid = 1'b0;
    last_ready = '0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  initial begin
    vld = '0;
    rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    drive();
    do_reset();

    // single request, basic product
    vld = 4'b0001; a_op[0] = 3'd7; b_op[0] = 5'd31;
    cycle();
    check("basic_ready", 32'(obs_ready), 32'd1);
    vld = '0;
    check("basic_valid", 32'(bus.rsp_valid), 32'd1);
    check("basic_id", 32'(bus.rsp_id), 32'd0);
    check("basic_prod", 32'(bus.rsp_product), 32'd89);
    check("basic_count", 32'(op_count), 32'd1);
    cycle();

    // round robin, all requesters continuously valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_op[i] = AW'(i + 1);
      b_op[i] = 5'd3;
    end
    vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_id", 32'(bus.rsp_id), 32'(k % N));
      check("rr_prod", 32'(bus.rsp_product), 32'(3 * ((k % N) + 1)));
    end

    // back-pressure with id 2 / product 20 held in the slot
    vld = '0;
    cycle();
    vld = 4'b0100; a_op[2] = 3'd4; b_op[2] = 5'd5;
    cycle();
    rdy = 1'b0;
    vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_ready", 32'(obs_ready), 32'd0);
      check("bp_id", 32'(bus.rsp_id), 32'd2);
      check("bp_prod", 32'(bus.rsp_product), 32'd20);
    end
    rdy = 1'b1;
    cycle();
    check("bp_next", 32'(obs_ready), 32'b1000);

    // idle requesters are skipped
    vld = 4'b0010;
    cycle();
    vld = 4'b1010;
    cycle();
    check("skip_g3", 32'(obs_ready), 32'b1000);
    cycle();
    check("skip_g1", 32'(obs_ready), 32'b0010);
    cycle();
    check("skip_g3b", 32'(obs_ready), 32'b1000);

    // counter wrap, then reset while the slot is full
    vld = '0;
    do_reset();
    vld = 4'b0001;
    for (int k = 0; k < 16; k++) cycle();
    check("wrap_count", 32'(op_count), 32'd0);
    check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    vld = 4'b1111;
    do_reset();
    cycle();
    check("rst_first", 32'(obs_ready), 32'b0001);

    // randomized traffic; stalled requesters keep their operands
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (vld[i] && !last_ready[i]) begin
          vld[i] = ($urandom_range(0, 9) != 0);
        end else begin
          vld[i]  = ($urandom_range(0, 1) != 0);
          a_op[i] = AW'($urandom_range(0, (1 << AW) - 1));
          b_op[i] = BW'($urandom_range(0, (1 << BW) - 1));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one combinational unsigned narrow multiplier (A_WIDTH x B_WIDTH -> P_WIDTH) between NUM_REQ requesters in the fiat_25519 carry_square datapath.
- Arbitration is round-robin.
- Each request is a valid/ready operand pair; each product comes back on a single registered response channel, tagged with the requester index.
- Replaces per-requester multiplier copies in area-optimised design points.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- A_WIDTH, 3, width of operand a.
- B_WIDTH, 5, width of operand b.
- P_WIDTH, 7, width of the product output. The full product is truncated to its low P_WIDTH bits.
- ID_WIDTH, 2, width of rsp_id; equals max(1, ceil(log2(NUM_REQ))).
- COUNT_WIDTH, 16, width of the accepted-operation counter.

Ports:
- ap_clk, in, 1: single clock. All state updates on the rising edge.
- ap_rst, in, 1: asynchronous, active-high reset.
- req_valid, in, NUM_REQ: bit i set means requester i presents operands.
- req_a, in, NUM_REQ*A_WIDTH: operand a of requester i at bits [i*A_WIDTH +: A_WIDTH].
- req_b, in, NUM_REQ*B_WIDTH: operand b of requester i at bits [i*B_WIDTH +: B_WIDTH].
- req_ready, out, NUM_REQ: one-hot or zero. Bit i means requester i's operands are accepted this cycle.
- rsp_valid, out, 1: response register holds a product.
- rsp_ready, in, 1: consumer accepts the response this cycle.
- rsp_id, out, ID_WIDTH: index of the requester that owns rsp_product.
- rsp_product, out, P_WIDTH: (a*b) mod 2^P_WIDTH, with both operands unsigned.
- op_count, out, COUNT_WIDTH: number of accepted requests, wrapping modulo 2^COUNT_WIDTH.

Behaviour:
- State: response register {rsp_valid, rsp_id, rsp_product}, round-robin pointer last_grant, and op_count.
- The response register acts as a two-state FSM:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- Reset while ap_rst=1, asynchronously:
  - rsp_valid=0, rsp_id=0, rsp_product=0, op_count=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready is forced to 0.
- can_load = !rsp_valid || rsp_ready.
- Grant selection (combinational):
  - Pick the first i with req_valid[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - If no bit is set, there is no grant.
- req_ready[grant] = can_load. All other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid.
  - req_ready never depends on rsp_product.
- Accept = can_load && a grant exists. On the accepting edge:
  - rsp_product <= truncated product of the granted operands.
  - rsp_id <= grant.
  - rsp_valid <= 1.
  - last_grant <= grant.
  - op_count <= op_count+1, wrapping to 0.
- If rsp_ready=1 and there is no accept: rsp_valid <= 0. rsp_id and rsp_product keep their last value.
- If rsp_valid=1 and rsp_ready=0: rsp_valid, rsp_id and rsp_product hold stable; no accept occurs.
- Simultaneous drain and accept in one cycle: rsp_valid stays 1 and the new result replaces the old one. This gives full throughput of one product per cycle.
- Latency: operands accepted at edge k produce a response visible from edge k onward, so it can be consumed in the cycle after k.
- The multiply is purely combinational inside the block.
  - Operands are zero-extended to A_WIDTH+B_WIDTH.
  - Bits at and above P_WIDTH are discarded.
  - There are no overflow flags.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants are strictly cyclic. A requester waits at most NUM_REQ-1 accepts.
- A requester may deassert req_valid before being granted; nothing is recorded for it.
  - Operands must stay stable while req_valid=1 && req_ready=0. This is a requester obligation; the bench asserts it.
- NUM_REQ=1: rsp_id is constantly 0 and arbitration degenerates to pass-through.
- Reset asserted mid-operation: any pending response is dropped and the pointer returns to NUM_REQ-1. No partial response appears after reset release.

Test Plan:
- Single request, basic product: after reset, req_valid=0001 with a=7, b=31 -> req_ready=0001 for one cycle; next cycle rsp_valid=1, rsp_id=0, rsp_product=89 (217 mod 128); op_count=1.
- Round-robin ordering: req_valid=1111 held, rsp_ready=1, a_i=i+1, b_i=3 -> rsp_id sequence 0,1,2,3,0 with products 3,6,9,12,3, one per cycle.
- Back-pressure: rsp_ready=0 for 5 cycles with response FULL (id 2, product 20) -> response stable and all req_ready=0; rsp_ready=1 -> next grant follows id 2 (id 3 if valid).
- Skipping idle requesters: req_valid=1010 after last_grant=1 -> grant 3; then grant 1; requesters 0 and 2 are never granted.
- Counter wrap and reset: with COUNT_WIDTH=4, 16 accepts -> op_count=0. Assert ap_rst mid-stream with rsp_valid=1 -> outputs reset immediately and the first grant after release goes to requester 0.
